// File: rtl/mult_adder_sched_pkg.sv
// Shared definitions for the multiply-adder tree sequencer: default sizing,
// the log2 helper used to derive tree latency and counter widths, and the beat tag.
package mult_adder_sched_pkg;

    localparam int DEF_TREE_SIZE = 8;
    localparam int DEF_LANE_W    = 8;
    localparam int DEF_SUM_W     = 20;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_PASSES    = 4;
    localparam int DEF_RES_DEPTH = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One multiply stage plus one adder stage per tree level.
    localparam int DEF_LAT = 1 + clog2(DEF_TREE_SIZE);

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/mult_adder_sched_if.sv
// Operand-beat input and result output handshakes of the tree sequencer.
interface mult_adder_sched_if #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_kernel;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_kernel, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_kernel, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mult_adder_res_fifo.sv
// Result buffer between the accumulator and the conv output writer.
// Head reads as zero while empty so the output bus is clean after reset.
module mult_adder_res_fifo
    import mult_adder_sched_pkg::*;
#(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count are, and head is masked while empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/mult_adder_sched.sv
// Sequencer for the pipelined multiply-adder tree: admits operand beats under a
// result-slot credit, tracks them with a tag pipe, and accumulates PASSES tree sums per result.
module mult_adder_sched
    import mult_adder_sched_pkg::*;
#(
    parameter int TREE_SIZE = DEF_TREE_SIZE,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int PASSES    = DEF_PASSES,
    parameter int RES_DEPTH = DEF_RES_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    mult_adder_sched_if.slave           bus,
    output logic [TREE_SIZE*LANE_W-1:0] ma_in,
    output logic [TREE_SIZE*LANE_W-1:0] ma_kernel,
    output logic                        ma_reset_n,
    input  logic [SUM_W-1:0]            ma_sum,
    input  logic                        ma_carry,
    output logic                        busy
);
    localparam int LAT  = 1 + clog2(TREE_SIZE);
    localparam int PC_W = (PASSES > 1) ? clog2(PASSES) : 1;
    localparam int OC_W = clog2(RES_DEPTH + 1);

    tag_t [LAT-1:0]   tag_pipe;
    tag_t             tag_in;
    tag_t             tag_out;
    logic [PC_W-1:0]  pass_cnt;
    logic [OC_W-1:0]  open_cnt;
    logic [OC_W-1:0]  fifo_count;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_sticky;
    logic             ovf_next;
    logic             in_flight;
    logic             fire;
    logic             pop;
    logic             push;
    logic             group_first;
    logic             group_last;
    logic             opening;
    logic             fifo_empty;
    logic [ACC_W:0]   fifo_head;

    assign ma_in     = bus.in_data;
    assign ma_kernel = bus.in_kernel;

    assign group_first = (pass_cnt == '0);
    assign group_last  = (pass_cnt == PC_W'(PASSES - 1));

    // A new group needs a guaranteed result slot; beats inside a group never wait.
    assign bus.in_ready = ~reset & (~group_first | (open_cnt < OC_W'(RES_DEPTH)));
    assign fire         = bus.in_valid & bus.in_ready;
    assign opening      = fire & group_first;
    assign pop          = bus.out_valid & bus.out_ready;

    assign tag_in  = '{valid: fire, last: group_last};
    assign tag_out = tag_pipe[LAT-1];
    assign push    = tag_out.valid & tag_out.last;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        acc_next  = acc + ACC_W'($signed(ma_sum));
        ovf_next  = ovf_sticky | ma_carry;
        in_flight = 1'b0;
        for (int i = 0; i < LAT; i++) in_flight |= tag_pipe[i].valid;
    end

    assign busy = in_flight | ~group_first | (open_cnt != '0);

    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
        ma_reset_n <= ~reset;
        if (reset) begin
            tag_pipe   <= '0;
            pass_cnt   <= '0;
            open_cnt   <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            tag_pipe <= {tag_pipe[LAT-2:0], tag_in};
            if (fire) pass_cnt <= group_last ? '0 : pass_cnt + 1'b1;
            if (opening && !pop)      open_cnt <= open_cnt + 1'b1;
            else if (!opening && pop) open_cnt <= open_cnt - 1'b1;
            if (tag_out.valid) begin
                acc        <= tag_out.last ? '0 : acc_next;
                ovf_sticky <= ~tag_out.last & ovf_next;
            end
        end
    end

    mult_adder_res_fifo #(
        .WIDTH (ACC_W + 1),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({ovf_next, acc_next}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.out_valid = ~fifo_empty;
    assign {bus.out_ovf, bus.out_data} = fifo_head;

    // Buffered results always belong to open groups.
    assert property (@(posedge clock) disable iff (reset) fifo_count <= open_cnt);

endmodule

// File: tb/tb_mult_adder_sched.sv
// Bench for mult_adder_sched with a delay-line tree stub (sum = low lanes of ma_in,
// carry = ma_kernel bit 0) and a transaction-level model of groups, credits and results.
module tb_mult_adder_sched;
    import mult_adder_sched_pkg::*;

    localparam int TS  = 4;
    localparam int LW  = 8;
    localparam int SW  = 16;
    localparam int AW  = 32;
    localparam int NP  = 2;
    localparam int RD  = 2;
    localparam int LAT = 1 + clog2(TS);
    localparam int DW  = TS * LW;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] ma_in;
    logic [DW-1:0] ma_kernel;
    logic          ma_reset_n;
    logic [SW-1:0] ma_sum;
    logic          ma_carry;
    logic          busy;

    always #5 clock = ~clock;

    mult_adder_sched_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    mult_adder_sched #(
        .TREE_SIZE (TS), .LANE_W (LW), .SUM_W (SW),
        .ACC_W (AW), .PASSES (NP), .RES_DEPTH (RD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .ma_in      (ma_in),
        .ma_kernel  (ma_kernel),
        .ma_reset_n (ma_reset_n),
        .ma_sum     (ma_sum),
        .ma_carry   (ma_carry),
        .busy       (busy)
    );

    // Tree stub: pure LAT-cycle delay line, unaware of beat validity.
    logic [SW:0] stub_pipe [LAT];
    always @(posedge clock) begin
        stub_pipe[0] <= {ma_kernel[0], ma_in[SW-1:0]};
        for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign {ma_carry, ma_sum} = stub_pipe[LAT-1];

    typedef struct {
        logic [AW-1:0] data;
        logic          ovf;
        int            vis;
    } res_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    res_t          res_q[$];
    int            beat_idx;
    int            open_groups;
    logic [AW-1:0] m_acc;
    logic          m_ovf;
    logic          prev_reset;
    logic          obs_ready, obs_valid, obs_busy, obs_ovf;
    logic [AW-1:0] obs_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [SW-1:0] s);
        return {(DW-SW)'($urandom), s};
    endfunction

    function automatic logic [DW-1:0] ker(input logic c);
        return {(DW-1)'($urandom), c};
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
    task automatic tick(input logic rst, input logic vld, input logic [DW-1:0] d,
                        input logic [DW-1:0] k, input logic ordy);
        logic exp_ready, exp_valid, fire, pop;
        int   s;
        reset         = rst;
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.in_kernel = k;
        bus.out_ready = ordy;
        @(negedge clock);
        exp_ready = !rst && (beat_idx != 0 || open_groups < RD);
        exp_valid = 1'b0;
        if (res_q.size() > 0) exp_valid = (res_q[0].vis <= cyc);
        obs_ready = bus.in_ready;
        obs_valid = bus.out_valid;
        obs_busy  = busy;
        obs_data  = bus.out_data;
        obs_ovf   = bus.out_ovf;
        check("in_ready", bus.in_ready, exp_ready);
        check("out_valid", bus.out_valid, exp_valid);
        check("busy", busy, open_groups != 0);
        check("ma_reset_n", ma_reset_n, !prev_reset);
        check("pass", {ma_in, ma_kernel}, {d, k});
        if (exp_valid) begin
            check("out_data", bus.out_data, res_q[0].data);
            check("out_ovf", bus.out_ovf, res_q[0].ovf);
        end
        fire = vld && exp_ready;
        pop  = exp_valid && ordy;
        if (rst) begin
            res_q.delete();
            beat_idx    = 0;
            open_groups = 0;
            m_acc       = '0;
            m_ovf       = 1'b0;
        end else begin
            if (pop) begin
                void'(res_q.pop_front());
                open_groups--;
            end
            if (fire) begin
                if (beat_idx == 0) open_groups++;
                s     = $signed(d[SW-1:0]);
                m_acc = m_acc + s;
                m_ovf = m_ovf | k[0];
                if (beat_idx == NP - 1) begin
                    res_q.push_back('{data: m_acc, ovf: m_ovf, vis: cyc + LAT + 1});
                    m_acc    = '0;
                    m_ovf    = 1'b0;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
        end
        prev_reset = rst;
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic ordy);
        tick(1'b0, 1'b0, dat(SW'($urandom)), ker(1'b0), ordy);
    endtask

    task automatic beat(input logic [SW-1:0] s, input logic c, input logic ordy);
        tick(1'b0, 1'b1, dat(s), ker(c), ordy);
    endtask

    task automatic wait_result(input string tag, output int at, output logic [AW-1:0] d, output logic o);
        at = -1;
        d  = '0;
        o  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1'b1);
            if (obs_valid) begin
                at = cyc - 1;
                d  = obs_data;
                o  = obs_ovf;
                break;
            end
        end
        check({tag, "_seen"}, at >= 0, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, beat_idx != 0, dat(SW'($urandom)), ker(1'b0), 1'b1);
            if (!obs_busy) break;
        end
        check({tag, "_idle"}, obs_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int            t0, at;
        logic [AW-1:0] d;
        logic          o;
        logic          rdy [6];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_kernel = '0;
        bus.out_ready = 1'b0;
        beat_idx      = 0;
        open_groups   = 0;
        m_acc         = '0;
        m_ovf         = 1'b0;
        prev_reset    = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        idle(1'b0);
        check("rst_out_data", obs_data, '0);
        check("rst_out_ovf", obs_ovf, 1'b0);

        // Basic two-beat group and latency.
        t0 = cyc;
        beat(16'd4, 1'b0, 1'b1);
        beat(16'd4, 1'b0, 1'b1);
        wait_result("t1", at, d, o);
        check("t1_latency", at - t0, 5);
        check("t1_data", d, 32'd8);
        check("t1_ovf", o, 1'b0);

        // Sign extension of tree sums.
        beat(16'hFFF0, 1'b0, 1'b1);
        beat(16'h0004, 1'b0, 1'b1);
        wait_result("t2", at, d, o);
        check("t2_data", d, 32'hFFFF_FFF4);

        // Credit back-pressure with a stalled consumer.
        for (int i = 0; i < 6; i++) begin
            beat(SW'($urandom), 1'b0, 1'b0);
            rdy[i] = obs_ready;
        end
        for (int i = 0; i < 6; i++) check($sformatf("t3_rdy%0d", i), rdy[i], (i < 4) ? 1'b1 : 1'b0);
        beat(SW'($urandom), 1'b0, 1'b1);
        check("t3_pop_cycle_blocked", obs_ready, 1'b0);
        beat(SW'($urandom), 1'b0, 1'b0);
        check("t3_reopen", obs_ready, 1'b1);
        drain("t3");

        // Carry in group A must not leak into group B.
        beat(SW'($urandom), 1'b0, 1'b0);
        beat(SW'($urandom), 1'b1, 1'b0);
        beat(SW'($urandom), 1'b0, 1'b0);
        beat(SW'($urandom), 1'b0, 1'b0);
        wait_result("t4a", at, d, o);
        check("t4a_ovf", o, 1'b1);
        wait_result("t4b", at, d, o);
        check("t4b_ovf", o, 1'b0);
        drain("t4");

        // Reset mid-group discards the group.
        beat(SW'($urandom), 1'b0, 1'b1);
        idle(1'b1);
        tick(1'b1, 1'b0, '0, '0, 1'b1);
        idle(1'b1);
        check("t5_busy", obs_busy, 1'b0);
        check("t5_ready", obs_ready, 1'b1);
        check("t5_out_data", obs_data, '0);
        t0 = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (obs_valid) t0++;
        end
        check("t5_no_result", t0, 0);

        // Full FIFO: pop and new group's first beat in the same cycle.
        for (int i = 0; i < 4; i++) beat(SW'($urandom), 1'b0, 1'b0);
        repeat (LAT + 2) idle(1'b0);
        beat(SW'($urandom), 1'b0, 1'b1);
        check("t6_full_blocked", obs_ready, 1'b0);
        check("t6_full_valid", obs_valid, 1'b1);
        beat(SW'($urandom), 1'b0, 1'b1);
        check("t6_pop_and_open", obs_ready, 1'b1);
        beat(SW'($urandom), 1'b0, 1'b0);
        check("t6_mid_group", obs_ready, 1'b1);
        drain("t6");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [SW-1:0] s;
            case ($urandom_range(0, 5))
                0:       s = 16'h8000;
                1:       s = 16'h7FFF;
                2:       s = 16'hFFFF;
                default: s = SW'($urandom);
            endcase
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, dat(s),
                 ker($urandom_range(0, 7) == 0), $urandom_range(0, 2) != 0);
        end
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
